// File: rtl/imem_fetch_if.sv
// Fetch-side bus bundle: control inputs, ROM address/data and the decode handshake.
// The slave modport is the fetch controller; master is its environment.
interface imem_fetch_if;
  logic        start;
  logic        halt_req;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic        halted;

  modport master (
    output start, halt_req, redirect_valid, redirect_pc, imem_instr, if_ready,
    input  imem_pc, if_valid, if_instr, if_pc, halted
  );

  modport slave (
    input  start, halt_req, redirect_valid, redirect_pc, imem_instr, if_ready,
    output imem_pc, if_valid, if_instr, if_pc, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the combinational ROM and feeds
// decode through a 2-entry in-order buffer with redirect flush and halt handling.
module imem_fetch_ctrl #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst_n,
  imem_fetch_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [1:0]  count_q, count_d;
  logic [15:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [31:0] head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic        pop, push;

  always_comb begin
    pop  = (count_q != 2'd0) && bus.if_ready;
    push = (state_q == StFetch) && !bus.redirect_valid && ((count_q != 2'd2) || pop) &&
           !bus.halt_req;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = bus.halt_req ? StHalt : StFetch;
      StFetch: if (bus.halt_req || (push && (bus.imem_instr == HALT_WORD))) state_d = StHalt;
      StHalt:  if (bus.start && !bus.halt_req) state_d = StFetch;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 16'd1;
    end
  end

  // A pop shifts the tail into the head; a push lands in the head only if that
  // slot is free after the pop, otherwise it becomes the new tail.
  always_comb begin
    head_pc_d    = head_pc_q;
    head_instr_d = head_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_instr_d = tail_instr_q;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      head_pc_d    = tail_pc_q;
      head_instr_d = tail_instr_q;
    end
    if (push) begin
      if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
        head_pc_d    = fetch_pc_q;
        head_instr_d = bus.imem_instr;
      end else begin
        tail_pc_d    = fetch_pc_q;
        tail_instr_d = bus.imem_instr;
      end
    end
    if (bus.redirect_valid) begin
      count_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      count_q      <= 2'd0;
      head_pc_q    <= 16'h0000;
      head_instr_q <= 32'h0000_0000;
      tail_pc_q    <= 16'h0000;
      tail_instr_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      count_q      <= count_d;
      head_pc_q    <= head_pc_d;
      head_instr_q <= head_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_instr_q <= tail_instr_d;
    end
  end

  always_comb begin
    bus.imem_pc  = fetch_pc_q;
    bus.if_valid = (count_q != 2'd0);
    bus.if_pc    = bus.if_valid ? head_pc_q : 16'h0000;
    bus.if_instr = bus.if_valid ? head_instr_q : 32'h0000_0000;
    bus.halted   = (state_q == StHalt) && (count_q == 2'd0);
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus random traffic, compared every
// cycle against a queue-based model of the fetch/buffer rules.
module tb_imem_fetch_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  imem_fetch_if bus ();

  imem_fetch_ctrl #(
    .RESET_PC  (16'h0000),
    .HALT_WORD (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] rom_tbl [32];
  int          m_st;  // 0 idle, 1 fetching, 2 halted
  logic [15:0] m_pc;
  logic [47:0] m_q [$];

  function automatic logic [31:0] rom_read(input logic [15:0] a);
    if (a < 16'd32) return rom_tbl[a[4:0]];
    return (32'(a) * 32'h9E37_79B1 + 32'h1234_5678) & 32'h7FFF_FFFF;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [47:0] h;
    h = (m_q.size() > 0) ? m_q[0] : 48'h0;
    chk("if_valid", 48'(bus.if_valid), 48'(m_q.size() > 0));
    chk("if_pc", 48'(bus.if_pc), 48'(h[47:32]));
    chk("if_instr", 48'(bus.if_instr), 48'(h[31:0]));
    chk("imem_pc", 48'(bus.imem_pc), 48'(m_pc));
    chk("halted", 48'(bus.halted), 48'((m_st == 2) && (m_q.size() == 0)));
  endtask

  task automatic model_reset();
    m_st = 0;
    m_pc = 16'h0000;
    m_q.delete();
  endtask

  task automatic do_reset();
    bus.start          = 1'b0;
    bus.halt_req       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0;
    bus.if_ready       = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_valid", 48'(bus.if_valid), 48'h0);
    chk("rst_halted", 48'(bus.halted), 48'h0);
    chk("rst_imem_pc", 48'(bus.imem_pc), 48'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.imem_instr = rom_read(bus.imem_pc);
  endtask

  task automatic step(input logic st, input logic hr, input logic rv,
                      input logic [15:0] rpc, input logic rdy);
    logic        pop, push;
    logic [31:0] w;
    int          nst;
    bus.start          = st;
    bus.halt_req       = hr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    bus.imem_instr     = rom_read(bus.imem_pc);
    w    = rom_read(m_pc);
    pop  = (m_q.size() > 0) && rdy;
    push = (m_st == 1) && !rv && ((m_q.size() < 2) || pop) && !hr;
    nst  = m_st;
    if (m_st == 0 && st) nst = hr ? 2 : 1;
    else if (m_st == 1 && (hr || (push && w == 32'hFFFF_FFFF))) nst = 2;
    else if (m_st == 2 && st && !hr) nst = 1;
    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (rv) m_q.delete();
    else if (push) m_q.push_back({m_pc, w});
    m_pc = rv ? rpc : (push ? m_pc + 16'd1 : m_pc);
    m_st = nst;
    compare_all();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 16'h0, rdy);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_tbl[i] = 32'hA000_0000 + 32'(i);
    bus.imem_instr = 32'h0;
    model_reset();
    #2;

    // Streaming from reset with decode always ready.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    chk("t1_first_not_yet", 48'(bus.if_valid), 48'h0);
    idle(1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_pc", 48'(bus.if_pc), 48'(k));
      chk("t1_instr", 48'(bus.if_instr), 48'(32'hA000_0000 + 32'(k)));
      idle(1'b1);
    end

    // Backpressure fills both entries, then drains without a gap.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b0);
    chk("t2_head", 48'(bus.if_pc), 48'h0);
    chk("t2_imem_pc", 48'(bus.imem_pc), 48'h2);
    idle(1'b1);
    chk("t2_next1", 48'(bus.if_pc), 48'h1);
    idle(1'b1);
    chk("t2_next2", 48'(bus.if_pc), 48'h2);

    // Redirect while full flushes both entries.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0009, 1'b0);
    chk("t3_flushed", 48'(bus.if_valid), 48'h0);
    idle(1'b0);
    chk("t3_pc", 48'(bus.if_pc), 48'h9);
    chk("t3_instr", 48'(bus.if_instr), 48'hA000_0009);

    // HALT word stops fetching after it is delivered; start resumes.
    rom_tbl[2] = 32'hFFFF_FFFF;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("t4_halted", 48'(bus.halted), 48'h1);
    chk("t4_imem_pc", 48'(bus.imem_pc), 48'h3);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    idle(1'b1);
    chk("t4_resume", 48'(bus.if_pc), 48'h3);
    rom_tbl[2] = 32'hA000_0002;

    // PC wraps from FFFF to 0000.
    do_reset();
    step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    idle(1'b1);
    chk("t5_ffff", 48'(bus.if_pc), 48'hFFFF);
    idle(1'b1);
    chk("t5_wrap", 48'(bus.if_pc), 48'h0);

    // Asynchronous reset mid-stream with a full buffer; no fetch without start.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0);
    chk("t6_full", 48'(bus.if_valid), 48'h1);
    do_reset();
    for (int k = 0; k < 3; k++) idle(1'b1);
    chk("t6_no_fetch", 48'(bus.if_valid), 48'h0);

    // Random traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        st, hr, rv, rdy;
      logic [15:0] rpc;
      if (n % 200 == 0) begin
        for (int i = 0; i < 32; i++)
          rom_tbl[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : ($urandom & 32'h7FFF_FFFF);
      end
      if ($urandom_range(0, 299) == 0) do_reset();
      st  = ($urandom_range(0, 9) == 0);
      hr  = ($urandom_range(0, 19) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 9) < 7);
      step(st, hr, rv, rpc, rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
